// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges ALU and load/store results onto the single ROB writeback port.
// Each source has a small skid FIFO; the oldest head by ROB age wins, subject to a starvation guard.

module writeback_arbiter_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] head,
   output logic             valid,
   output logic             ready
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;

   // Ready is derived from the registered count only, so a same-edge pop does not free a slot early.
   assign ready = count < CNT_W'(DEPTH);
   assign valid = count != '0;
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= data;
      end
   end

endmodule

module writeback_arbiter #(
   parameter int FIFO_DEPTH   = 2,
   parameter int STARVE_LIMIT = 3,
   parameter int ROB_IDX_SIZE = 4,
   parameter int GPR_SIZE     = 64
) (
   input  logic                    in_clk,
   input  logic                    in_rst,
   input  logic                    in_alu_done,
   input  logic [ROB_IDX_SIZE-1:0] in_alu_dst_rob_index,
   input  logic [GPR_SIZE-1:0]     in_alu_value,
   input  logic                    in_alu_set_nzcv,
   input  logic [3:0]              in_alu_nzcv,
   output logic                    out_alu_ready,
   input  logic                    in_ls_done,
   input  logic [ROB_IDX_SIZE-1:0] in_ls_dst_rob_index,
   input  logic [GPR_SIZE-1:0]     in_ls_value,
   input  logic                    in_ls_set_nzcv,
   input  logic [3:0]              in_ls_nzcv,
   output logic                    out_ls_ready,
   input  logic [ROB_IDX_SIZE-1:0] in_rob_head_index,
   input  logic                    in_rob_flush,
   output logic                    out_rob_done,
   output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
   output logic [GPR_SIZE-1:0]     out_rob_value,
   output logic                    out_rob_set_nzcv,
   output logic [3:0]              out_rob_nzcv
);

   localparam int ENTRY_W  = ROB_IDX_SIZE + GPR_SIZE + 5;
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

   typedef struct packed {
      logic [ROB_IDX_SIZE-1:0] idx;
      logic [GPR_SIZE-1:0]     value;
      logic                    set_nzcv;
      logic [3:0]              nzcv;
   } entry_t;

   entry_t alu_entry;
   entry_t ls_entry;
   entry_t alu_head;
   entry_t ls_head;
   logic   alu_push;
   logic   ls_push;
   logic   alu_valid;
   logic   ls_valid;
   logic   alu_win;
   logic   ls_win;
   logic   [ROB_IDX_SIZE-1:0] alu_age;
   logic   [ROB_IDX_SIZE-1:0] ls_age;
   logic   [STARVE_W-1:0]     alu_starve;
   logic   [STARVE_W-1:0]     ls_starve;

   assign alu_entry = '{idx: in_alu_dst_rob_index, value: in_alu_value,
                        set_nzcv: in_alu_set_nzcv, nzcv: in_alu_nzcv};
   assign ls_entry  = '{idx: in_ls_dst_rob_index, value: in_ls_value,
                        set_nzcv: in_ls_set_nzcv, nzcv: in_ls_nzcv};

   assign alu_push = in_alu_done && out_alu_ready;
   assign ls_push  = in_ls_done && out_ls_ready;

   writeback_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) alu_fifo (
      .clk   (in_clk),
      .rst   (in_rst),
      .flush (in_rob_flush),
      .push  (alu_push),
      .pop   (alu_win),
      .data  (alu_entry),
      .head  (alu_head),
      .valid (alu_valid),
      .ready (out_alu_ready)
   );

   writeback_arbiter_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) ls_fifo (
      .clk   (in_clk),
      .rst   (in_rst),
      .flush (in_rob_flush),
      .push  (ls_push),
      .pop   (ls_win),
      .data  (ls_entry),
      .head  (ls_head),
      .valid (ls_valid),
      .ready (out_ls_ready)
   );

   // Age is the modular distance from the commit head, so wraparound of the ROB index is harmless.
   assign alu_age = alu_head.idx - in_rob_head_index;
   assign ls_age  = ls_head.idx - in_rob_head_index;

   always_comb begin
      alu_win = 1'b0;
      ls_win  = 1'b0;
      if (alu_valid && ls_valid) begin
         if (alu_starve == STARVE_MAX) begin
            alu_win = 1'b1;
         end else if (ls_starve == STARVE_MAX) begin
            ls_win = 1'b1;
         end else if (alu_age <= ls_age) begin
            alu_win = 1'b1;
         end else begin
            ls_win = 1'b1;
         end
      end else if (alu_valid) begin
         alu_win = 1'b1;
      end else if (ls_valid) begin
         ls_win = 1'b1;
      end
   end

   // A counter only climbs while its source has a head waiting and another source took the port.
   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         alu_starve <= '0;
         ls_starve  <= '0;
      end else if (in_rob_flush) begin
         alu_starve <= '0;
         ls_starve  <= '0;
      end else begin
         if (alu_valid && !alu_win) begin
            alu_starve <= (alu_starve == STARVE_MAX) ? alu_starve : alu_starve + STARVE_W'(1);
         end else begin
            alu_starve <= '0;
         end
         if (ls_valid && !ls_win) begin
            ls_starve <= (ls_starve == STARVE_MAX) ? ls_starve : ls_starve + STARVE_W'(1);
         end else begin
            ls_starve <= '0;
         end
      end
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         out_rob_done          <= 1'b0;
         out_rob_dst_rob_index <= '0;
         out_rob_value         <= '0;
         out_rob_set_nzcv      <= 1'b0;
         out_rob_nzcv          <= '0;
      end else if (in_rob_flush) begin
         out_rob_done <= 1'b0;
      end else begin
         out_rob_done <= alu_win || ls_win;
         if (alu_win) begin
            out_rob_dst_rob_index <= alu_head.idx;
            out_rob_value         <= alu_head.value;
            out_rob_set_nzcv      <= alu_head.set_nzcv;
            out_rob_nzcv          <= alu_head.nzcv;
         end else if (ls_win) begin
            out_rob_dst_rob_index <= ls_head.idx;
            out_rob_value         <= ls_head.value;
            out_rob_set_nzcv      <= ls_head.set_nzcv;
            out_rob_nzcv          <= ls_head.nzcv;
         end
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a queue-based model of the arbitration rules.

module tb_writeback_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 3;

   logic        in_clk;
   logic        in_rst;
   logic        in_alu_done;
   logic [3:0]  in_alu_dst_rob_index;
   logic [63:0] in_alu_value;
   logic        in_alu_set_nzcv;
   logic [3:0]  in_alu_nzcv;
   logic        out_alu_ready;
   logic        in_ls_done;
   logic [3:0]  in_ls_dst_rob_index;
   logic [63:0] in_ls_value;
   logic        in_ls_set_nzcv;
   logic [3:0]  in_ls_nzcv;
   logic        out_ls_ready;
   logic [3:0]  in_rob_head_index;
   logic        in_rob_flush;
   logic        out_rob_done;
   logic [3:0]  out_rob_dst_rob_index;
   logic [63:0] out_rob_value;
   logic        out_rob_set_nzcv;
   logic [3:0]  out_rob_nzcv;

   writeback_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT),
      .ROB_IDX_SIZE (4),
      .GPR_SIZE     (64)
   ) dut (
      .in_clk                (in_clk),
      .in_rst                (in_rst),
      .in_alu_done           (in_alu_done),
      .in_alu_dst_rob_index  (in_alu_dst_rob_index),
      .in_alu_value          (in_alu_value),
      .in_alu_set_nzcv       (in_alu_set_nzcv),
      .in_alu_nzcv           (in_alu_nzcv),
      .out_alu_ready         (out_alu_ready),
      .in_ls_done            (in_ls_done),
      .in_ls_dst_rob_index   (in_ls_dst_rob_index),
      .in_ls_value           (in_ls_value),
      .in_ls_set_nzcv        (in_ls_set_nzcv),
      .in_ls_nzcv            (in_ls_nzcv),
      .out_ls_ready          (out_ls_ready),
      .in_rob_head_index     (in_rob_head_index),
      .in_rob_flush          (in_rob_flush),
      .out_rob_done          (out_rob_done),
      .out_rob_dst_rob_index (out_rob_dst_rob_index),
      .out_rob_value         (out_rob_value),
      .out_rob_set_nzcv      (out_rob_set_nzcv),
      .out_rob_nzcv          (out_rob_nzcv)
   );

   initial begin
      in_clk = 1'b0;
      forever #5 in_clk = ~in_clk;
   end

   typedef struct {
      logic [3:0]  idx;
      logic [63:0] value;
      logic        set_nzcv;
      logic [3:0]  nzcv;
   } result_t;

   int      tests = 0;
   int      failures = 0;
   bit      model_on = 0;
   result_t alu_q[$];
   result_t ls_q[$];
   int      alu_lost = 0;
   int      ls_lost = 0;
   logic    exp_done = 1'b0;
   result_t exp_out;

   task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int age(input logic [3:0] idx);
      return (int'(idx) - int'(in_rob_head_index) + 16) % 16;
   endfunction

   // 0 = nobody, 1 = ALU, 2 = LS, decided from the queue heads and loss history.
   function automatic int pick_winner();
      if (alu_q.size() == 0 && ls_q.size() == 0) return 0;
      if (ls_q.size() == 0) return 1;
      if (alu_q.size() == 0) return 2;
      if (alu_lost == LIMIT) return 1;
      if (ls_lost == LIMIT) return 2;
      return (age(alu_q[0].idx) <= age(ls_q[0].idx)) ? 1 : 2;
   endfunction

   initial begin
      exp_out = '{idx: 4'h0, value: 64'h0, set_nzcv: 1'b0, nzcv: 4'h0};
      forever begin
         @(posedge in_clk or posedge in_rst);
         if (in_rst || in_rob_flush) begin
            alu_q.delete();
            ls_q.delete();
            alu_lost = 0;
            ls_lost  = 0;
            exp_done = 1'b0;
         end else begin
            automatic bit alu_acc = in_alu_done && (alu_q.size() < DEPTH);
            automatic bit ls_acc  = in_ls_done && (ls_q.size() < DEPTH);
            automatic bit alu_had = alu_q.size() != 0;
            automatic bit ls_had  = ls_q.size() != 0;
            automatic int w = pick_winner();
            exp_done = (w != 0);
            if (w == 1) exp_out = alu_q.pop_front();
            if (w == 2) exp_out = ls_q.pop_front();
            alu_lost = (alu_had && w != 1) ? ((alu_lost < LIMIT) ? alu_lost + 1 : LIMIT) : 0;
            ls_lost  = (ls_had && w != 2) ? ((ls_lost < LIMIT) ? ls_lost + 1 : LIMIT) : 0;
            if (alu_acc) alu_q.push_back('{in_alu_dst_rob_index, in_alu_value, in_alu_set_nzcv, in_alu_nzcv});
            if (ls_acc) ls_q.push_back('{in_ls_dst_rob_index, in_ls_value, in_ls_set_nzcv, in_ls_nzcv});
         end
      end
   end

   always @(negedge in_clk) begin
      if (model_on && !in_rst) begin
         check_output("model_done", out_rob_done, exp_done);
         check_output("model_alu_ready", out_alu_ready, alu_q.size() < DEPTH);
         check_output("model_ls_ready", out_ls_ready, ls_q.size() < DEPTH);
         if (exp_done) begin
            check_output("model_idx", out_rob_dst_rob_index, exp_out.idx);
            check_output("model_value", out_rob_value, exp_out.value);
            check_output("model_set_nzcv", out_rob_set_nzcv, exp_out.set_nzcv);
            check_output("model_nzcv", out_rob_nzcv, exp_out.nzcv);
         end
      end
   end

   task automatic set_alu(input logic d, input logic [3:0] i, input logic [63:0] v, input logic s, input logic [3:0] n);
      in_alu_done = d;
      in_alu_dst_rob_index = i;
      in_alu_value = v;
      in_alu_set_nzcv = s;
      in_alu_nzcv = n;
   endtask

   task automatic set_ls(input logic d, input logic [3:0] i, input logic [63:0] v, input logic s, input logic [3:0] n);
      in_ls_done = d;
      in_ls_dst_rob_index = i;
      in_ls_value = v;
      in_ls_set_nzcv = s;
      in_ls_nzcv = n;
   endtask

   task automatic idle();
      set_alu(1'b0, 4'h0, 64'h0, 1'b0, 4'h0);
      set_ls(1'b0, 4'h0, 64'h0, 1'b0, 4'h0);
      in_rob_flush = 1'b0;
   endtask

   task automatic clear_all();
      idle();
      in_rob_flush = 1'b1;
      @(negedge in_clk);
      in_rob_flush = 1'b0;
   endtask

   task automatic apply_stimulus();
      set_alu($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom},
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      set_ls($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)), {$urandom, $urandom},
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      in_rob_flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 7) == 0) in_rob_head_index = 4'($urandom_range(0, 15));
   endtask

   initial begin
      logic [3:0] seen[$];
      logic [3:0] starve_exp[6];
      int   ls_next;
      int   ls_acc;
      bit   ls_rdy;
      bit   bp_checked;

      in_rst = 1'b1;
      in_rob_head_index = 4'h0;
      idle();
      #1;
      check_output("reset_done", out_rob_done, 0);
      check_output("reset_alu_ready", out_alu_ready, 1);
      check_output("reset_ls_ready", out_ls_ready, 1);
      check_output("reset_value", out_rob_value, 0);
      @(negedge in_clk);
      in_rst = 1'b0;
      model_on = 1'b1;

      // Single ALU result: visible exactly one cycle after the edge following acceptance.
      set_alu(1'b1, 4'd3, 64'h2A, 1'b1, 4'b0100);
      @(negedge in_clk);
      idle();
      check_output("single_early", out_rob_done, 0);
      @(negedge in_clk);
      check_output("single_done", out_rob_done, 1);
      check_output("single_idx", out_rob_dst_rob_index, 3);
      check_output("single_value", out_rob_value, 64'h2A);
      check_output("single_set", out_rob_set_nzcv, 1);
      check_output("single_nzcv", out_rob_nzcv, 4'b0100);
      @(negedge in_clk);
      check_output("single_pulse", out_rob_done, 0);

      // Age priority across the ROB index wrap, then ALU priority on equal age.
      in_rob_head_index = 4'd14;
      set_alu(1'b1, 4'd1, 64'hA1, 1'b0, 4'h0);
      set_ls(1'b1, 4'd15, 64'hB1, 1'b0, 4'h0);
      @(negedge in_clk);
      idle();
      @(negedge in_clk);
      check_output("wrap_first_idx", out_rob_dst_rob_index, 15);
      @(negedge in_clk);
      check_output("wrap_second_idx", out_rob_dst_rob_index, 1);
      in_rob_head_index = 4'd0;
      set_alu(1'b1, 4'd5, 64'hA5, 1'b0, 4'h0);
      set_ls(1'b1, 4'd5, 64'hB5, 1'b0, 4'h0);
      @(negedge in_clk);
      idle();
      @(negedge in_clk);
      check_output("tie_first_value", out_rob_value, 64'hA5);
      @(negedge in_clk);
      check_output("tie_second_value", out_rob_value, 64'hB5);
      clear_all();

      // Backpressure: the LS unit holds each result until it sees ready at the accepting edge.
      ls_next = 2;
      ls_acc = 0;
      bp_checked = 0;
      for (int c = 0; c < 14; c++) begin
         set_alu(1'b1, 4'd0, 64'hA000 + 64'(c), 1'b0, 4'h0);
         if (ls_next <= 4) set_ls(1'b1, 4'(ls_next), 64'hB000 + 64'(ls_next), 1'b0, 4'h0);
         else set_ls(1'b0, 4'h0, 64'h0, 1'b0, 4'h0);
         ls_rdy = out_ls_ready;
         @(negedge in_clk);
         if (in_ls_done && ls_rdy) begin
            ls_next++;
            ls_acc++;
         end
         if (ls_acc == 2 && !bp_checked) begin
            check_output("bp_ls_full", out_ls_ready, 0);
            bp_checked = 1;
         end
      end
      check_output("bp_ls_accepts", ls_acc, 3);
      clear_all();

      // Starvation: LS idx 9 loses three times to a young ALU stream, then is forced through.
      in_rob_head_index = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (i < 5) set_alu(1'b1, 4'(i), 64'hC0 + 64'(i), 1'b0, 4'h0);
         else set_alu(1'b0, 4'h0, 64'h0, 1'b0, 4'h0);
         set_ls(i == 0, 4'd9, 64'hD9, 1'b0, 4'h0);
         @(negedge in_clk);
         if (out_rob_done) seen.push_back(out_rob_dst_rob_index);
      end
      idle();
      starve_exp = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd3, 4'd4};
      check_output("starve_count", seen.size(), 6);
      for (int k = 0; k < 6; k++) begin
         check_output("starve_order", (k < seen.size()) ? seen[k] : 4'hx, starve_exp[k]);
      end
      clear_all();

      // Flush with two ALU and one LS entries queued and a writeback in flight.
      set_alu(1'b1, 4'd1, 64'hE1, 1'b0, 4'h0);
      set_ls(1'b1, 4'd0, 64'hF0, 1'b0, 4'h0);
      @(negedge in_clk);
      set_alu(1'b1, 4'd2, 64'hE2, 1'b0, 4'h0);
      set_ls(1'b1, 4'd7, 64'hF7, 1'b0, 4'h0);
      @(negedge in_clk);
      check_output("flush_pre_done", out_rob_done, 1);
      check_output("flush_pre_idx", out_rob_dst_rob_index, 0);
      check_output("flush_pre_alu_full", out_alu_ready, 0);
      idle();
      set_alu(1'b1, 4'd5, 64'hE5, 1'b0, 4'h0);
      in_rob_flush = 1'b1;
      @(negedge in_clk);
      idle();
      check_output("flush_done", out_rob_done, 0);
      check_output("flush_alu_ready", out_alu_ready, 1);
      check_output("flush_ls_ready", out_ls_ready, 1);
      for (int k = 0; k < 4; k++) begin
         @(negedge in_clk);
         check_output("flush_quiet", out_rob_done, 0);
      end

      // Asynchronous reset between edges while results are queued.
      set_alu(1'b1, 4'd1, 64'h11, 1'b1, 4'h3);
      set_ls(1'b1, 4'd2, 64'h22, 1'b0, 4'h0);
      @(negedge in_clk);
      idle();
      @(negedge in_clk);
      check_output("areset_pre_done", out_rob_done, 1);
      #2 in_rst = 1'b1;
      #1;
      check_output("areset_done", out_rob_done, 0);
      check_output("areset_idx", out_rob_dst_rob_index, 0);
      check_output("areset_value", out_rob_value, 0);
      check_output("areset_nzcv", {out_rob_set_nzcv, out_rob_nzcv}, 0);
      check_output("areset_readies", {out_alu_ready, out_ls_ready}, 2'b11);
      @(negedge in_clk);
      in_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge in_clk);
         check_output("areset_quiet", out_rob_done, 0);
      end

      // Randomized traffic, checked every cycle by the model.
      for (int c = 0; c < 600; c++) begin
         apply_stimulus();
         @(negedge in_clk);
      end
      idle();
      repeat (4) @(negedge in_clk);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
